kernel_cra_pipe_bridge: RTL and testbench

KERNEL_CRA_PIPE_BRIDGE -- requirements
Module: kernel_cra_pipe_bridge

---
 rtl/kernel_cra_pipe_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_kernel_cra_pipe_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_cra_pipe_bridge.sv
// kernel_cra_pipe_bridge: fully registered CRA bridge from the board master to the kernel slave.
// Optional read timeout (DEADBEEF response) is built in when CRA_TIMEOUT_EN is defined.
module kernel_cra_pipe_bridge #(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                kernel_clk_clk,
  input  logic                kernel_reset_reset,
  input  logic                opencl_freeze,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic                s_burstcount,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [3:0]          pending_count,
  output logic                err_sticky
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned GRACE_W = 4;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_t;

  cmd_t                head_q, head_d, skid_q, skid_d, in_cmd;
  logic                head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic                m_read_q, m_read_d, m_write_q, m_write_d;
  logic                s_wait_q, s_wait_d;
  logic                s_rdv_q, s_rdv_d;
  logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;
  logic [3:0]          pending_q, pending_d;
  logic                err_q, err_d;
  logic [GRACE_W-1:0]  grace_q, grace_d;

  logic                accept, retire, rd_retire, rsp_ok, rsp_orphan, to_fire;
  logic                unused_ok;

`ifdef CRA_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned REP  = (DATA_W + 31) / 32;
  localparam logic [DATA_W-1:0] TO_DATA = DATA_W'({REP{32'hDEADBEEF}});

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog on the oldest outstanding read; any read progress restarts it.
  always_comb begin
    to_fire  = (pending_q != 4'd0) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))
               && !m_readdatavalid && !rd_retire;
    to_cnt_d = to_cnt_q;
    if (m_readdatavalid || rd_retire || to_fire || (pending_q == 4'd0)) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = TO_W'(to_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (kernel_reset_reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign unused_ok = s_burstcount;
`else
  always_comb begin
    to_fire = 1'b0;
  end

  assign unused_ok = s_burstcount ^ (TIMEOUT_CYCLES == 0);
`endif

  // Handshake qualifiers for both sides.
  always_comb begin
    in_cmd.wr   = s_write;
    in_cmd.addr = s_address;
    in_cmd.data = s_writedata;
    in_cmd.be   = s_byteenable;
    accept      = (s_read | s_write) & ~s_wait_q;
    retire      = (m_read_q | m_write_q) & ~m_waitrequest;
    rd_retire   = m_read_q & ~m_waitrequest;
    rsp_ok      = m_readdatavalid & (pending_q != 4'd0);
    rsp_orphan  = m_readdatavalid & (pending_q == 4'd0);
  end

  // Skid buffer, pending tracking, response path and registered next outputs.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    err_d      = err_q;
    grace_d    = grace_q;
    s_rdv_d    = 1'b0;
    s_rdata_d  = s_rdata_q;

    // The skid slot is only ever occupied behind a valid head.
    if (retire || !head_vld_q) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) begin
          skid_d = in_cmd;
        end
      end else begin
        head_vld_d = accept;
        if (accept) begin
          head_d = in_cmd;
        end
      end
    end else if (accept) begin
      skid_d     = in_cmd;
      skid_vld_d = 1'b1;
    end

    pending_d = pending_q + 4'(rd_retire) - 4'(rsp_ok) - 4'(to_fire);

    if (rsp_ok) begin
      s_rdv_d   = 1'b1;
      s_rdata_d = m_readdata;
    end
`ifdef CRA_TIMEOUT_EN
    if (to_fire) begin
      s_rdv_d   = 1'b1;
      s_rdata_d = TO_DATA;
    end
`endif

    if (grace_q != '0) begin
      grace_d = grace_q - GRACE_W'(1);
    end

    // Orphan responses right after reset belong to reads killed by that reset.
    if ((accept && s_read && s_write) || (rsp_orphan && (grace_q == '0)) || to_fire) begin
      err_d = 1'b1;
    end

    m_write_d = head_vld_d & head_d.wr;
    m_read_d  = head_vld_d & ~head_d.wr & (pending_d < 4'(MAX_PENDING));
    s_wait_d  = (head_vld_d & skid_vld_d) | opencl_freeze;
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (kernel_reset_reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      s_wait_q   <= 1'b1;
      s_rdv_q    <= 1'b0;
      s_rdata_q  <= '0;
      pending_q  <= 4'd0;
      err_q      <= 1'b0;
      grace_q    <= GRACE_W'(8);
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      s_wait_q   <= s_wait_d;
      s_rdv_q    <= s_rdv_d;
      s_rdata_q  <= s_rdata_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      grace_q    <= grace_d;
    end
  end

  assign m_address       = head_q.addr;
  assign m_writedata     = head_q.data;
  assign m_byteenable    = head_q.be;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign s_waitrequest   = s_wait_q;
  assign s_readdatavalid = s_rdv_q;
  assign s_readdata      = s_rdata_q;
  assign pending_count   = pending_q;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_kernel_cra_pipe_bridge.sv
// Directed bench for kernel_cra_pipe_bridge; timeout scenario selected by CRA_TIMEOUT_EN.
module tb_kernel_cra_pipe_bridge;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              opencl_freeze;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_read, s_write;
  logic              s_burstcount;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_read, m_write;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic [3:0]        pending_count;
  logic              err_sticky;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [ADDR_W:0] log_q[$];

  kernel_cra_pipe_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .kernel_clk_clk    (clk),
    .kernel_reset_reset(rst),
    .opencl_freeze     (opencl_freeze),
    .s_address         (s_address),
    .s_writedata       (s_writedata),
    .s_byteenable      (s_byteenable),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_burstcount      (s_burstcount),
    .s_waitrequest     (s_waitrequest),
    .s_readdata        (s_readdata),
    .s_readdatavalid   (s_readdatavalid),
    .m_address         (m_address),
    .m_writedata       (m_writedata),
    .m_byteenable      (m_byteenable),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .pending_count     (pending_count),
    .err_sticky        (err_sticky)
  );

  always #5 clk = ~clk;

  // Records every command the kernel side accepts: {is_write, address}.
  always @(posedge clk) begin
    if (!rst && (m_read || m_write) && !m_waitrequest) begin
      log_q.push_back({m_write, m_address});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W:0] ent(input logic wr, input int unsigned addr);
    return {wr, ADDR_W'(addr)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_read = 1'b0; s_write = 1'b0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0; opencl_freeze = 1'b0;
    tick(); tick();
    chk("rst_wait",    64'(s_waitrequest),   1);
    chk("rst_mread",   64'(m_read),          0);
    chk("rst_mwrite",  64'(m_write),         0);
    chk("rst_rdv",     64'(s_readdatavalid), 0);
    chk("rst_rdata",   s_readdata,           0);
    chk("rst_pending", 64'(pending_count),   0);
    chk("rst_err",     64'(err_sticky),      0);
    chk("rst_maddr",   64'(m_address),       0);
    rst = 1'b0;
    tick();
    chk("rst_wait_rel", 64'(s_waitrequest), 0);
  endtask

  task automatic issue_read(input int unsigned addr);
    s_read = 1'b1; s_address = ADDR_W'(addr);
    tick();
    s_read = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opencl_freeze = 1'b0; s_burstcount = 1'b1;
    s_address = '0; s_writedata = '0; s_byteenable = '1;
    s_read = 1'b0; s_write = 1'b0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    do_reset();

    // Single write: presented one cycle after accept, gone the next.
    log_q.delete();
    s_write = 1'b1; s_address = ADDR_W'(32'h10); s_writedata = 64'h1234; s_byteenable = 8'hFF;
    tick();
    s_write = 1'b0;
    chk("wr_mwrite", 64'(m_write),      1);
    chk("wr_mread",  64'(m_read),       0);
    chk("wr_addr",   64'(m_address),    64'h10);
    chk("wr_data",   m_writedata,       64'h1234);
    chk("wr_be",     64'(m_byteenable), 64'hFF);
    tick();
    chk("wr_done",    64'(m_write),       0);
    chk("wr_pending", 64'(pending_count), 0);
    chk("wr_log",     64'(log_q.size()),  1);

    // Six back-to-back reads against a 4-deep outstanding limit.
    log_q.delete();
    for (int i = 0; i < 6; i++) begin
      s_read = 1'b1; s_address = ADDR_W'(32'h100 + 4 * i);
      tick();
      if (i == 0) begin
        chk("rd1_mread", 64'(m_read),    1);
        chk("rd1_addr",  64'(m_address), 64'h100);
      end
      if (i == 4) begin
        chk("rd5_held",    64'(m_read),        0);
        chk("rd5_pending", 64'(pending_count), 4);
        chk("rd5_wait",    64'(s_waitrequest), 0);
      end
    end
    s_read = 1'b0;
    chk("rd_issued4", 64'(log_q.size()),  4);
    chk("rd_full",    64'(s_waitrequest), 1);
    chk("rd_block",   64'(m_read),        0);
    tick(); tick();
    chk("rd_still_held", 64'(m_read),       0);
    chk("rd_still4",     64'(log_q.size()), 4);
    m_readdatavalid = 1'b1; m_readdata = 64'h1111_2222_3333_4444;
    tick();
    m_readdatavalid = 1'b0;
    chk("rsp1_rdv",     64'(s_readdatavalid), 1);
    chk("rsp1_data",    s_readdata,           64'h1111_2222_3333_4444);
    chk("rd5_release",  64'(m_read),          1);
    chk("rd5_addr",     64'(m_address),       64'h110);
    chk("rsp1_pending", 64'(pending_count),   3);
    tick();
    chk("rd5_issued",  64'(log_q.size()),    5);
    chk("rd5_pend4",   64'(pending_count),   4);
    chk("rd_unfull",   64'(s_waitrequest),   0);
    chk("rsp1_rdv_lo", 64'(s_readdatavalid), 0);
    for (int i = 0; i < 5; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 64'(i + 2);
      tick();
    end
    m_readdatavalid = 1'b0;
    chk("drain_pending", 64'(pending_count), 0);
    chk("drain_issued",  64'(log_q.size()),  6);
    chk("drain_err",     64'(err_sticky),    0);
    for (int k = 0; k < 6; k++) begin
      chk("rd_order", 64'(log_q[k]), 64'(ent(1'b0, 32'h100 + 4 * k)));
    end

    // Three writes against a stalled kernel slave.
    log_q.delete();
    m_waitrequest = 1'b1;
    s_write = 1'b1; s_address = ADDR_W'(32'h200); s_writedata = 64'hD1;
    tick();
    s_address = ADDR_W'(32'h204); s_writedata = 64'hD2;
    tick();
    s_address = ADDR_W'(32'h208); s_writedata = 64'hD3;
    chk("stall_wait2", 64'(s_waitrequest), 1);
    repeat (8) tick();
    chk("stall_wait",  64'(s_waitrequest), 1);
    chk("stall_mwr",   64'(m_write),       1);
    chk("stall_addr",  64'(m_address),     64'h200);
    chk("stall_log",   64'(log_q.size()),  0);
    m_waitrequest = 1'b0;
    tick();
    chk("stall_w2",     64'(m_address),     64'h204);
    chk("stall_wait_lo", 64'(s_waitrequest), 0);
    tick();
    s_write = 1'b0;
    chk("stall_w3",    64'(m_address),   64'h208);
    chk("stall_w3_d",  m_writedata,      64'hD3);
    tick();
    chk("stall_idle",  64'(m_write),      0);
    chk("stall_log3",  64'(log_q.size()), 3);
    for (int k = 0; k < 3; k++) begin
      chk("wr_order", 64'(log_q[k]), 64'(ent(1'b1, 32'h200 + 4 * k)));
    end

    // Read retire and response in the same cycle with one read outstanding.
    issue_read(32'h300);
    chk("same_pre", 64'(pending_count), 1);
    s_read = 1'b1; s_address = ADDR_W'(32'h304);
    tick();
    s_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 64'hCAFE_F00D_0000_0001;
    tick();
    m_readdatavalid = 1'b0;
    chk("same_pending", 64'(pending_count),   1);
    chk("same_rdv",     64'(s_readdatavalid), 1);
    chk("same_data",    s_readdata,           64'hCAFE_F00D_0000_0001);
    m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    chk("same_drain", 64'(pending_count), 0);

    // Orphan response long after reset.
    tick();
    m_readdatavalid = 1'b1; m_readdata = 64'hBAD;
    tick();
    m_readdatavalid = 1'b0;
    chk("orph_rdv", 64'(s_readdatavalid), 0);
    chk("orph_err", 64'(err_sticky),      1);
    tick(); tick();
    chk("orph_sticky", 64'(err_sticky), 1);
    do_reset();

    // Simultaneous read and write is taken as a write and flagged.
    log_q.delete();
    s_read = 1'b1; s_write = 1'b1; s_address = ADDR_W'(32'h500); s_writedata = 64'h55;
    tick();
    s_read = 1'b0; s_write = 1'b0;
    chk("rw_mwrite", 64'(m_write),    1);
    chk("rw_mread",  64'(m_read),     0);
    chk("rw_err",    64'(err_sticky), 1);
    tick();
    chk("rw_pending", 64'(pending_count), 0);
    chk("rw_log",     64'(log_q[0]),      64'(ent(1'b1, 32'h500)));
    do_reset();

    // Responses to reads killed by reset are dropped silently for a while.
    issue_read(32'h600);
    issue_read(32'h604);
    chk("kill_pre", 64'(pending_count), 2);
    do_reset();
    m_readdatavalid = 1'b1; m_readdata = 64'h77;
    tick();
    chk("kill_rdv1", 64'(s_readdatavalid), 0);
    tick();
    m_readdatavalid = 1'b0;
    chk("kill_rdv2", 64'(s_readdatavalid), 0);
    chk("kill_err",  64'(err_sticky),      0);
    repeat (8) tick();
    m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    chk("late_orph_err", 64'(err_sticky),      1);
    chk("late_orph_rdv", 64'(s_readdatavalid), 0);
    do_reset();

    // Freeze blocks acceptance but lets a buffered command drain.
    log_q.delete();
    m_waitrequest = 1'b1;
    s_write = 1'b1; s_address = ADDR_W'(32'h400); s_writedata = 64'hF1;
    tick();
    s_write = 1'b0; opencl_freeze = 1'b1;
    tick();
    chk("frz_wait", 64'(s_waitrequest), 1);
    chk("frz_mwr",  64'(m_write),       1);
    s_write = 1'b1; s_address = ADDR_W'(32'h404); s_writedata = 64'hF2;
    m_waitrequest = 1'b0;
    tick();
    chk("frz_drained", 64'(m_write),      0);
    chk("frz_log",     64'(log_q.size()), 1);
    tick(); tick();
    chk("frz_block", 64'(m_write),       0);
    chk("frz_wait2", 64'(s_waitrequest), 1);
    opencl_freeze = 1'b0;
    tick();
    chk("unfrz_wait", 64'(s_waitrequest), 0);
    tick();
    s_write = 1'b0;
    chk("unfrz_mwr",  64'(m_write),   1);
    chk("unfrz_addr", 64'(m_address), 64'h404);
    tick();
    chk("unfrz_log", 64'(log_q.size()), 2);
    do_reset();

`ifdef CRA_TIMEOUT_EN
    // Unanswered read times out 16 cycles after issue.
    issue_read(32'h700);
    repeat (15) tick();
    chk("to_early", 64'(s_readdatavalid), 0);
    tick();
    chk("to_rdv",     64'(s_readdatavalid), 1);
    chk("to_data",    s_readdata,           64'hDEADBEEF_DEADBEEF);
    chk("to_pending", 64'(pending_count),   0);
    chk("to_err",     64'(err_sticky),      1);
`else
    // Without the timeout an unanswered read stays outstanding.
    issue_read(32'h700);
    repeat (20) tick();
    chk("nto_rdv",     64'(s_readdatavalid), 0);
    chk("nto_pending", 64'(pending_count),   1);
    chk("nto_err",     64'(err_sticky),      0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
